// File: rtl/pkt_scheduler_if.sv
// Handshake bundle between the frame scheduler, its two source FIFOs and the
// slave (sink) FIFO. The scheduler uses the master view; the environment
// driving the FIFOs uses the slave view.
interface pkt_scheduler_if;
  logic       src0_ready;
  logic       src0_rd;
  logic [7:0] src0_data;
  logic       src1_ready;
  logic       src1_rd;
  logic [7:0] src1_data;
  logic       sink_afull;
  logic       sink_wr;
  logic [7:0] sink_data;

  modport master (
    input  src0_ready, src0_data, src1_ready, src1_data, sink_afull,
    output src0_rd, src1_rd, sink_wr, sink_data
  );

  modport slave (
    output src0_ready, src0_data, src1_ready, src1_data, sink_afull,
    input  src0_rd, src1_rd, sink_wr, sink_data
  );
endinterface

// File: rtl/pkt_scheduler.sv
// Two-channel frame scheduler: arbitrates between two source FIFOs and wraps
// each granted payload into a frame (A0|ch, 32-bit sequence, payload, 77)
// written into the sink FIFO. A frame granted while the sink is almost full
// is still drained from its source but never written, and is counted as dropped.
module pkt_scheduler #(
  parameter int PAY0_LEN = 1020,
  parameter int PAY1_LEN = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  pkt_scheduler_if.master bus,
  output logic            busy,
  output logic [15:0]     drop_cnt,
  output logic            err_drop
);

  typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} state_t;

  localparam logic [9:0] LEN0 = 10'(PAY0_LEN);
  localparam logic [9:0] LEN1 = 10'(PAY1_LEN);

  state_t      state, state_next;
  logic [9:0]  cnt, cnt_next;
  logic        ch;
  logic        drop;
  logic        last_ch;
  logic        armed;
  logic [31:0] seq0, seq1;
  logic        grant, grant_ch;
  logic [9:0]  pay_len;
  logic [31:0] seq_cur;
  logic [7:0]  src_data;
  logic        rd_active;
  logic [7:0]  data_next;
  logic        wr_next;

  assign pay_len     = ch ? LEN1 : LEN0;
  assign seq_cur     = ch ? seq1 : seq0;
  assign src_data    = ch ? bus.src1_data : bus.src0_data;
  assign busy        = (state != IDLE);
  assign bus.src0_rd = rd_active & ~ch;
  assign bus.src1_rd = rd_active & ch;

  // Round-robin arbitration, only in IDLE and only once armed after reset
  always_comb begin
    grant    = 1'b0;
    grant_ch = 1'b0;
    if (state == IDLE && armed && enable) begin
      if (bus.src0_ready && bus.src1_ready) begin
        grant    = 1'b1;
        grant_ch = ~last_ch;
      end else if (bus.src0_ready) begin
        grant    = 1'b1;
        grant_ch = 1'b0;
      end else if (bus.src1_ready) begin
        grant    = 1'b1;
        grant_ch = 1'b1;
      end
    end
  end

  // Next state, frame counter, source read strobe and next sink byte
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rd_active  = 1'b0;
    data_next  = 8'h00;
    wr_next    = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          state_next = HDR;
          cnt_next   = 10'd0;
          data_next  = {7'b1010000, grant_ch};
          wr_next    = ~bus.sink_afull;
        end
      end
      HDR: begin
        rd_active = (cnt >= 10'd3);
        wr_next   = ~drop;
        case (cnt[2:0])
          3'd0:    data_next = seq_cur[31:24];
          3'd1:    data_next = seq_cur[23:16];
          3'd2:    data_next = seq_cur[15:8];
          3'd3:    data_next = seq_cur[7:0];
          default: data_next = src_data;
        endcase
        if (cnt == 10'd4) begin
          state_next = PAY;
          cnt_next   = 10'd0;
        end else begin
          cnt_next = cnt + 10'd1;
        end
      end
      PAY: begin
        rd_active = (cnt < pay_len - 10'd2);
        wr_next   = ~drop;
        if (cnt == pay_len - 10'd1) begin
          data_next  = 8'h77;
          state_next = TRL;
          cnt_next   = 10'd0;
        end else begin
          data_next = src_data;
          cnt_next  = cnt + 10'd1;
        end
      end
      TRL: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Frame context, registered sink outputs, sequence and drop bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= 10'd0;
      ch            <= 1'b0;
      drop          <= 1'b0;
      last_ch       <= 1'b1;
      armed         <= 1'b0;
      seq0          <= 32'd1;
      seq1          <= 32'd1;
      bus.sink_data <= 8'h00;
      bus.sink_wr   <= 1'b0;
      err_drop      <= 1'b0;
      drop_cnt      <= 16'd0;
    end else begin
      armed         <= 1'b1;
      cnt           <= cnt_next;
      bus.sink_data <= data_next;
      bus.sink_wr   <= wr_next;
      err_drop      <= grant & bus.sink_afull;
      if (grant) begin
        ch      <= grant_ch;
        last_ch <= grant_ch;
        drop    <= bus.sink_afull;
        if (bus.sink_afull && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      if (state == TRL) begin
        if (ch) seq1 <= seq1 + 32'd1;
        else    seq0 <= seq0 + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pkt_scheduler.sv
// Directed testbench for pkt_scheduler with small payload lengths. Source
// FIFOs are modelled as incrementing byte streams with one cycle read latency.
module tb_pkt_scheduler;
  localparam int L0 = 8;
  localparam int L1 = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        busy;
  logic [15:0] drop_cnt;
  logic        err_drop;

  int tests = 0;
  int failures = 0;

  pkt_scheduler_if bus();

  pkt_scheduler #(.PAY0_LEN(L0), .PAY1_LEN(L1)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .bus(bus),
    .busy(busy),
    .drop_cnt(drop_cnt),
    .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  // Source FIFO models: each read returns the next byte one cycle later
  logic [7:0] fifo0_next = 8'h10;
  logic [7:0] fifo1_next = 8'hC0;
  always @(posedge clk) begin
    if (bus.src0_rd) begin
      bus.src0_data <= fifo0_next;
      fifo0_next    <= fifo0_next + 8'd1;
    end
    if (bus.src1_rd) begin
      bus.src1_data <= fifo1_next;
      fifo1_next    <= fifo1_next + 8'd1;
    end
  end

  // Sink monitor: collects written bytes and counts reads and drop pulses
  logic [7:0] got[$];
  int rd0_cycles = 0;
  int rd1_cycles = 0;
  int err_pulses = 0;
  always @(negedge clk) begin
    if (bus.sink_wr) got.push_back(bus.sink_data);
    if (bus.src0_rd) rd0_cycles++;
    if (bus.src1_rd) rd1_cycles++;
    if (err_drop) err_pulses++;
  end

  // Expected byte stream, built independently of the FIFO models
  logic [7:0] exp[$];
  logic [7:0] exp0_next = 8'h10;
  logic [7:0] exp1_next = 8'hC0;

  function automatic void push_frame(input logic c, input logic [31:0] seq, input bit written);
    int len;
    len = c ? L1 : L0;
    if (written) begin
      exp.push_back({7'b1010000, c});
      exp.push_back(seq[31:24]);
      exp.push_back(seq[23:16]);
      exp.push_back(seq[15:8]);
      exp.push_back(seq[7:0]);
    end
    for (int j = 0; j < len; j++) begin
      if (written) exp.push_back(c ? exp1_next : exp0_next);
      if (c) exp1_next = exp1_next + 8'd1;
      else   exp0_next = exp0_next + 8'd1;
    end
    if (written) exp.push_back(8'h77);
  endfunction

  task automatic clear_capture();
    got.delete();
    exp.delete();
    rd0_cycles = 0;
    rd1_cycles = 0;
    err_pulses = 0;
  endtask

  task automatic wait_busy(input logic level, input int budget, input string what);
    int n;
    n = 0;
    while (busy !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== level) begin
      tests++;
      failures++;
      $display("[TB] FAIL timeout_%s: busy=%b required %b", what, busy, level);
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n        = 1'b0;
    enable         = 1'b0;
    bus.src0_ready = 1'b0;
    bus.src1_ready = 1'b0;
    bus.sink_afull = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    enable         = 1'b0;
    bus.src0_ready = 1'b0;
    bus.src1_ready = 1'b0;
    bus.sink_afull = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, bus.src0_rd, bus.src1_rd, bus.sink_wr, err_drop} !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: busy/rd0/rd1/wr/err=%b required 00000",
               {busy, bus.src0_rd, bus.src1_rd, bus.sink_wr, err_drop});
    end
    tests++;
    if (bus.sink_data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_data: sink_data=%02h required 00", bus.sink_data);
    end
    tests++;
    if (drop_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_drop_cnt: drop_cnt=%0d required 0", drop_cnt);
    end
    reset_n        = 1'b1;
    enable         = 1'b1;
    bus.src0_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_first_edge: busy=%b required 0", busy);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_second_edge: busy=%b required 1", busy);
    end
    bus.src0_ready = 1'b0;
    push_frame(1'b0, 32'd1, 1'b0);
    wait_busy(1'b0, 100, "reset_frame");
    settle();
  endtask

  task automatic test_single_frame();
    logic rd_exp;
    apply_reset();
    clear_capture();
    push_frame(1'b0, 32'd1, 1'b1);
    enable         = 1'b1;
    bus.src0_ready = 1'b1;
    @(negedge clk);
    bus.src0_ready = 1'b0;
    for (int i = 0; i < L0 + 6; i++) begin
      rd_exp = (i >= 3) && (i < 3 + L0);
      tests++;
      if (bus.sink_wr !== 1'b1 || bus.sink_data !== exp[i]) begin
        failures++;
        $display("[TB] FAIL single_byte[%0d]: wr=%b data=%02h required wr=1 data=%02h",
                 i, bus.sink_wr, bus.sink_data, exp[i]);
      end
      tests++;
      if ({bus.src0_rd, bus.src1_rd} !== {rd_exp, 1'b0}) begin
        failures++;
        $display("[TB] FAIL single_rd[%0d]: rd0/rd1=%b%b required %b0",
                 i, bus.src0_rd, bus.src1_rd, rd_exp);
      end
      @(negedge clk);
    end
    tests++;
    if (bus.sink_wr !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_end: wr=%b busy=%b required 0 0", bus.sink_wr, busy);
    end
    settle();
  endtask

  task automatic test_round_robin();
    apply_reset();
    clear_capture();
    push_frame(1'b0, 32'd1, 1'b1);
    push_frame(1'b1, 32'd1, 1'b1);
    push_frame(1'b0, 32'd2, 1'b1);
    push_frame(1'b1, 32'd2, 1'b1);
    enable         = 1'b1;
    bus.src0_ready = 1'b1;
    bus.src1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_busy(1'b1, 20, "rr_start");
      if (k == 3) begin
        bus.src0_ready = 1'b0;
        bus.src1_ready = 1'b0;
      end
      wait_busy(1'b0, 100, "rr_end");
    end
    settle();
    tests++;
    if (got.size() != exp.size()) begin
      failures++;
      $display("[TB] FAIL rr_len: got %0d bytes required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("[TB] FAIL rr_byte[%0d]: got %02h required %02h", i, got[i], exp[i]);
      end
    end
    tests++;
    if (rd0_cycles != 2 * L0 || rd1_cycles != 2 * L1) begin
      failures++;
      $display("[TB] FAIL rr_reads: rd0=%0d rd1=%0d required %0d %0d",
               rd0_cycles, rd1_cycles, 2 * L0, 2 * L1);
    end
  endtask

  task automatic test_drop();
    apply_reset();
    clear_capture();
    push_frame(1'b0, 32'd1, 1'b0);
    enable         = 1'b1;
    bus.sink_afull = 1'b1;
    bus.src0_ready = 1'b1;
    @(negedge clk);
    bus.sink_afull = 1'b0;
    bus.src0_ready = 1'b0;
    tests++;
    if (err_drop !== 1'b1 || drop_cnt !== 16'd1) begin
      failures++;
      $display("[TB] FAIL drop_flag: err_drop=%b drop_cnt=%0d required 1 1", err_drop, drop_cnt);
    end
    @(negedge clk);
    tests++;
    if (err_drop !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drop_pulse_len: err_drop=%b required 0", err_drop);
    end
    wait_busy(1'b0, 100, "drop_end");
    settle();
    tests++;
    if (got.size() != 0 || rd0_cycles != L0 || err_pulses != 1) begin
      failures++;
      $display("[TB] FAIL drop_frame: writes=%0d rd0=%0d pulses=%0d required 0 %0d 1",
               got.size(), rd0_cycles, err_pulses, L0);
    end
    clear_capture();
    push_frame(1'b0, 32'd2, 1'b1);
    bus.src0_ready = 1'b1;
    @(negedge clk);
    bus.src0_ready = 1'b0;
    bus.sink_afull = 1'b1;
    wait_busy(1'b0, 100, "after_drop_end");
    bus.sink_afull = 1'b0;
    settle();
    tests++;
    if (got.size() != exp.size()) begin
      failures++;
      $display("[TB] FAIL after_drop_len: got %0d bytes required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("[TB] FAIL after_drop_byte[%0d]: got %02h required %02h", i, got[i], exp[i]);
      end
    end
    tests++;
    if (drop_cnt !== 16'd1) begin
      failures++;
      $display("[TB] FAIL drop_cnt_hold: drop_cnt=%0d required 1", drop_cnt);
    end
  endtask

  task automatic test_seq_wrap();
    apply_reset();
    clear_capture();
    force dut.seq0 = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.seq0;
    push_frame(1'b0, 32'hFFFFFFFF, 1'b1);
    push_frame(1'b0, 32'h00000000, 1'b1);
    enable         = 1'b1;
    bus.src0_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_busy(1'b1, 20, "wrap_start");
      if (k == 1) bus.src0_ready = 1'b0;
      wait_busy(1'b0, 100, "wrap_end");
    end
    settle();
    tests++;
    if (got.size() != exp.size()) begin
      failures++;
      $display("[TB] FAIL wrap_len: got %0d bytes required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("[TB] FAIL wrap_byte[%0d]: got %02h required %02h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_enable_deassert();
    clear_capture();
    push_frame(1'b0, 32'd1, 1'b1);
    enable         = 1'b1;
    bus.src0_ready = 1'b1;
    wait_busy(1'b1, 20, "enable_start");
    repeat (6) @(negedge clk);
    enable = 1'b0;
    wait_busy(1'b0, 100, "enable_end");
    settle();
    tests++;
    if (got.size() != exp.size()) begin
      failures++;
      $display("[TB] FAIL enable_len: got %0d bytes required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("[TB] FAIL enable_byte[%0d]: got %02h required %02h", i, got[i], exp[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL enable_idle[%0d]: busy=%b required 0", i, busy);
      end
    end
    bus.src0_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    enable         = 1'b1;
    bus.src0_ready = 1'b1;
    wait_busy(1'b1, 20, "midreset_start");
    bus.src0_ready = 1'b0;
    repeat (7) @(negedge clk);
    tests++;
    if (bus.src0_rd !== 1'b1 || bus.sink_wr !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_active: rd0=%b wr=%b required 1 1", bus.src0_rd, bus.sink_wr);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({bus.src0_rd, bus.src1_rd, bus.sink_wr, busy} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL midreset_abort: rd0/rd1/wr/busy=%b required 0000",
               {bus.src0_rd, bus.src1_rd, bus.sink_wr, busy});
    end
    exp0_next = exp0_next + 8'd4;
    clear_capture();
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (got.size() != 0 || rd0_cycles != 0) begin
      failures++;
      $display("[TB] FAIL midreset_quiet: writes=%0d rd0=%0d required 0 0", got.size(), rd0_cycles);
    end
    push_frame(1'b0, 32'd1, 1'b1);
    enable         = 1'b1;
    bus.src0_ready = 1'b1;
    wait_busy(1'b1, 20, "midreset_next");
    bus.src0_ready = 1'b0;
    wait_busy(1'b0, 100, "midreset_next_end");
    settle();
    tests++;
    if (got.size() != exp.size()) begin
      failures++;
      $display("[TB] FAIL midreset_len: got %0d bytes required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("[TB] FAIL midreset_byte[%0d]: got %02h required %02h", i, got[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_drop();
    test_seq_wrap();
    test_enable_deassert();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
